control_sequencer: RTL

Multi-cycle, parametrised successor to the CPU's combinational control decoder. It accepts instructions over a valid/ready handshake, latches them into an internal instruction register, and decodes the class and field bits. It tracks stack depth with overflow/underflow protection and sequences optional stack-memory access through a request/acknowledge handshake. It then emits the datapath control strobes for exactly one execute cycle. It sits between the fetch unit and the datapath/stack memory.

---
 rtl/cpu_ctrl_pkg.sv | 56 +++++
 rtl/ctrl_decode.sv | 49 ++++
 rtl/control_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared states, codes, field positions and strobe bundle for the control sequencer
package cpu_ctrl_pkg;

  // Sequencer states
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_MEM    = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  // Instruction classes
  localparam logic [1:0] CLS_ALU    = 2'b00;
  localparam logic [1:0] CLS_BRANCH = 2'b01;
  localparam logic [1:0] CLS_LIT    = 2'b10;
  localparam logic [1:0] CLS_ILL    = 2'b11;

  // Fault codes
  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_OVF  = 2'b01;
  localparam logic [1:0] FLT_UNF  = 2'b10;
  localparam logic [1:0] FLT_ILL  = 2'b11;

  // Stack-pointer delta codes
  localparam logic [1:0] SPD_NONE = 2'b00;
  localparam logic [1:0] SPD_INC  = 2'b01;
  localparam logic [1:0] SPD_DEC  = 2'b10;
  localparam logic [1:0] SPD_DEC2 = 2'b11;

  // Field positions, counted from bit 0 on the MSB side of the instruction
  localparam int B_CLS      = 0;
  localparam int B_CARRY    = 2;
  localparam int B_OP       = 3;
  localparam int B_STK_SEL  = 3;
  localparam int B_ADDR_SEL = 4;
  localparam int B_R_W      = 6;
  localparam int B_STK_W    = 7;
  localparam int B_SPD      = 8;
  localparam int B_JSEL     = 10;
  localparam int B_JMASK    = 12;

  // Datapath strobe bundle
  typedef struct packed {
    logic       stk_w;
    logic       carry_w;
    logic       r_w;
    logic       stk_sel;
    logic       addr_sel;
    logic [4:0] op;
    logic       sp_inc;
    logic       sp_dec2;
    logic       sp_dec;
    logic [1:0] jsel;
    logic [5:0] jmask;
  } ctrl_strobes_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational instruction-register to strobe/sp-delta decode
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int IW = 18
) (
  input  logic [IW-1:0] ir_i,
  output ctrl_strobes_t strb_o,
  output logic [1:0]    cls_o,
  output logic [1:0]    sp_delta_o,
  output logic          need_mem_o
);

  // Instruction bit k (MSB-side numbering) lives at f[17-k]; bits beyond 17 are ignored
  logic [17:0] f;
  assign f = ir_i[IW-1 -: 18];

  // Field decode: every strobe defaults to 0 and only the owning class drives it
  always_comb begin
    strb_o     = '0;
    sp_delta_o = SPD_NONE;
    cls_o      = f[17-B_CLS -: 2];
    case (cls_o)
      CLS_ALU: begin
        strb_o.carry_w  = f[17-B_CARRY];
        strb_o.op       = f[17-B_OP -: 5];
        strb_o.stk_sel  = f[17-B_STK_SEL];
        strb_o.addr_sel = f[17-B_ADDR_SEL] & ~f[17-B_STK_SEL];
        strb_o.r_w      = f[17-B_R_W];
        strb_o.stk_w    = f[17-B_STK_W] & f[17-B_STK_SEL];
        sp_delta_o      = f[17-B_SPD -: 2];
      end
      CLS_BRANCH: begin
        strb_o.jsel  = f[17-B_JSEL -: 2];
        strb_o.jmask = f[17-B_JMASK -: 6];
      end
      CLS_LIT: begin
        strb_o.stk_w = 1'b1;
        sp_delta_o   = SPD_INC;
      end
      default: ;
    endcase
    strb_o.sp_inc  = (sp_delta_o == SPD_INC);
    strb_o.sp_dec  = (sp_delta_o == SPD_DEC);
    strb_o.sp_dec2 = (sp_delta_o == SPD_DEC2);
    need_mem_o     = strb_o.stk_w | strb_o.addr_sel;
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle control sequencer with stack bounds and memory handshake
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int IW          = 18,
  parameter int SP_DEPTH    = 16,
  parameter int SPW         = $clog2(SP_DEPTH + 1),
  parameter int CHECK_STACK = 1
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_instr_valid,
  input  logic [IW-1:0]  i_instruction,
  output logic           o_instr_ready,
  output logic           o_mem_req,
  output logic           o_mem_we,
  input  logic           i_mem_ack,
  output logic           o_exec,
  output logic           o_stk_w,
  output logic           o_carry_w,
  output logic           o_r_w,
  output logic           o_stk_sel,
  output logic           o_addr_sel,
  output logic [4:0]     o_op,
  output logic           o_sp_inc,
  output logic           o_sp_dec2,
  output logic           o_sp_dec,
  output logic [1:0]     o_jsel,
  output logic [5:0]     o_jmask,
  output logic [SPW-1:0] o_depth,
  output logic           o_fault,
  output logic [1:0]     o_fault_code,
  input  logic           i_fault_clr
);

  localparam logic [SPW-1:0] DEPTH_MAX = SPW'(SP_DEPTH);

  logic [2:0]     state_q, state_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [SPW-1:0] depth_q, depth_d;
  logic [1:0]     fault_code_q, fault_code_d;
  ctrl_strobes_t  out_q, out_d;
  logic           exec_q, exec_d;
  logic           mem_req_q, mem_req_d;
  logic           mem_we_q, mem_we_d;

  ctrl_strobes_t  dec_strb;
  logic [1:0]     dec_cls;
  logic [1:0]     dec_spd;
  logic           dec_mem;
  logic           push;
  logic [SPW-1:0] pop_n;

  ctrl_decode #(.IW(IW)) u_decode (
    .ir_i       (ir_q),
    .strb_o     (dec_strb),
    .cls_o      (dec_cls),
    .sp_delta_o (dec_spd),
    .need_mem_o (dec_mem)
  );

  // Translate the sp delta into a push flag and a pop count for bounds checks and depth update
  always_comb begin
    push  = (dec_spd == SPD_INC);
    pop_n = '0;
    if (dec_spd == SPD_DEC) begin
      pop_n = SPW'(1);
    end else if (dec_spd == SPD_DEC2) begin
      pop_n = SPW'(2);
    end
  end

  // Next state, fault capture, depth update and staging of the registered outputs
  always_comb begin
    state_d      = state_q;
    fault_code_d = fault_code_q;
    depth_d      = depth_q;
    ir_d         = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (i_instr_valid) begin
          ir_d    = i_instruction;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_cls == CLS_ILL) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_ILL;
        end else if ((CHECK_STACK != 0) && push && (depth_q == DEPTH_MAX)) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_OVF;
        end else if ((CHECK_STACK != 0) && (depth_q < pop_n)) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_UNF;
        end else if (dec_mem) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_MEM: begin
        if (i_mem_ack) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        depth_d = depth_q + (push ? SPW'(1) : SPW'(0)) - pop_n;
      end
      ST_FAULT: begin
        if (i_fault_clr) begin
          state_d      = ST_FETCH;
          fault_code_d = FLT_NONE;
        end
      end
      default: state_d = ST_FETCH;
    endcase
    exec_d    = (state_d == ST_EXEC);
    out_d     = exec_d ? dec_strb : '0;
    mem_req_d = (state_d == ST_MEM);
    mem_we_d  = mem_req_d & dec_strb.stk_w;
  end

  // State and registered outputs; reset clears everything asynchronously
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_FETCH;
      ir_q         <= '0;
      depth_q      <= '0;
      fault_code_q <= FLT_NONE;
      out_q        <= '0;
      exec_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      depth_q      <= depth_d;
      fault_code_q <= fault_code_d;
      out_q        <= out_d;
      exec_q       <= exec_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
    end
  end

  assign o_instr_ready = (state_q == ST_FETCH);
  assign o_fault       = (state_q == ST_FAULT);
  assign o_fault_code  = fault_code_q;
  assign o_depth       = depth_q;
  assign o_mem_req     = mem_req_q;
  assign o_mem_we      = mem_we_q;
  assign o_exec        = exec_q;
  assign o_stk_w       = out_q.stk_w;
  assign o_carry_w     = out_q.carry_w;
  assign o_r_w         = out_q.r_w;
  assign o_stk_sel     = out_q.stk_sel;
  assign o_addr_sel    = out_q.addr_sel;
  assign o_op          = out_q.op;
  assign o_sp_inc      = out_q.sp_inc;
  assign o_sp_dec2     = out_q.sp_dec2;
  assign o_sp_dec      = out_q.sp_dec;
  assign o_jsel        = out_q.jsel;
  assign o_jmask       = out_q.jmask;

endmodule
